// File: rtl/ras_ctrl.sv
// Return-address stack for the fetch stage: classifies jumps by link-register hints,
// keeps a circular buffer of return addresses and offers one-level checkpoint/recovery.
module ras_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 8
) (
    input  logic                       in_Clk,
    input  logic                       in_Rst_N,
    input  logic                       in_valid,
    input  logic [6:0]                 in_opcode,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rs1,
    input  logic [DATA_WIDTH-1:0]      in_pc,
    input  logic                       in_checkpoint,
    input  logic                       in_recover,
    output logic                       out_pred_valid,
    output logic [DATA_WIDTH-1:0]      out_pred_target,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       out_empty,
    output logic                       out_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_PUSH,
        OP_POP,
        OP_POPPUSH
    } op_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]          tos_reg, tos_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [PW-1:0]          ck_tos_reg, ck_tos_next;
    logic [CW-1:0]          ck_count_reg, ck_count_next;
    logic                   pred_valid_reg, pred_valid_next;
    logic [DATA_WIDTH-1:0]  pred_target_reg, pred_target_next;
    logic                   empty_reg, empty_next;
    logic                   full_reg, full_next;

    op_e                    op;
    logic                   rd_link, rs1_link;
    logic                   wr_en;
    logic [PW-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic [DATA_WIDTH-1:0]  top_data;
    logic                   is_full;

    assign rd_link  = (in_rd == 5'd1) || (in_rd == 5'd5);
    assign rs1_link = (in_rs1 == 5'd1) || (in_rs1 == 5'd5);
    assign top_data = mem[tos_reg];
    assign is_full  = (count_reg == CW'(DEPTH));
    assign wr_data  = in_pc + DATA_WIDTH'(4);

    // Link-register hint classification; a recovering cycle drops the instruction.
    always_comb begin
        op = OP_NONE;
        if (in_valid && !in_recover) begin
            if (in_opcode == OPC_JAL) begin
                if (rd_link) op = OP_PUSH;
            end else if (in_opcode == OPC_JALR) begin
                unique case ({rd_link, rs1_link})
                    2'b10:   op = OP_PUSH;
                    2'b01:   op = OP_POP;
                    2'b11:   op = (in_rd != in_rs1) ? OP_POPPUSH : OP_PUSH;
                    default: op = OP_NONE;
                endcase
            end
        end
    end

    always_comb begin
        tos_next         = tos_reg;
        count_next       = count_reg;
        ck_tos_next      = ck_tos_reg;
        ck_count_next    = ck_count_reg;
        pred_valid_next  = 1'b0;
        pred_target_next = pred_target_reg;
        wr_en            = 1'b0;
        wr_addr          = tos_reg + PW'(1);

        if (in_recover) begin
            tos_next   = ck_tos_reg;
            count_next = ck_count_reg;
        end else begin
            unique case (op)
                OP_PUSH: begin
                    wr_en      = 1'b1;
                    tos_next   = tos_reg + PW'(1);
                    count_next = is_full ? count_reg : count_reg + CW'(1);
                end
                OP_POP: begin
                    if (count_reg != '0) begin
                        pred_valid_next  = 1'b1;
                        pred_target_next = top_data;
                        tos_next         = tos_reg - PW'(1);
                        count_next       = count_reg - CW'(1);
                    end
                end
                OP_POPPUSH: begin
                    if (count_reg != '0) begin
                        // Replace the popped entry in place: tos and count stay put.
                        pred_valid_next  = 1'b1;
                        pred_target_next = top_data;
                        wr_en            = 1'b1;
                        wr_addr          = tos_reg;
                    end else begin
                        wr_en      = 1'b1;
                        tos_next   = tos_reg + PW'(1);
                        count_next = count_reg + CW'(1);
                    end
                end
                default: ;
            endcase
            if (in_checkpoint) begin
                ck_tos_next   = tos_reg;
                ck_count_next = count_reg;
            end
        end

        empty_next = (count_next == '0);
        full_next  = (count_next == CW'(DEPTH));
    end

    always_ff @(posedge in_Clk or negedge in_Rst_N) begin
        if (!in_Rst_N) begin
            tos_reg         <= '0;
            count_reg       <= '0;
            ck_tos_reg      <= '0;
            ck_count_reg    <= '0;
            pred_valid_reg  <= 1'b0;
            pred_target_reg <= '0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
        end else begin
            tos_reg         <= tos_next;
            count_reg       <= count_next;
            ck_tos_reg      <= ck_tos_next;
            ck_count_reg    <= ck_count_next;
            pred_valid_reg  <= pred_valid_next;
            pred_target_reg <= pred_target_next;
            empty_reg       <= empty_next;
            full_reg        <= full_next;
        end
    end

    // Entry storage is not reset; writes are suppressed while reset is held.
    always_ff @(posedge in_Clk) begin
        if (wr_en && in_Rst_N) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign out_pred_valid  = pred_valid_reg;
    assign out_pred_target = pred_target_reg;
    assign out_count       = count_reg;
    assign out_empty       = empty_reg;
    assign out_full        = full_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: a behavioural stack model queues expected outputs
// per driven instruction, and they are compared one cycle later.
module tb_ras_ctrl;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [6:0] JAL  = 7'h6f;
    localparam logic [6:0] JALR = 7'h67;
    localparam logic [6:0] ALU  = 7'h33;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [DW-1:0] pc;
    logic          checkpoint;
    logic          recover;
    logic          pred_valid;
    logic [DW-1:0] pred_target;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    ras_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .in_Clk          (clk),
        .in_Rst_N        (rst_n),
        .in_valid        (valid),
        .in_opcode       (opcode),
        .in_rd           (rd),
        .in_rs1          (rs1),
        .in_pc           (pc),
        .in_checkpoint   (checkpoint),
        .in_recover      (recover),
        .out_pred_valid  (pred_valid),
        .out_pred_target (pred_target),
        .out_count       (count),
        .out_empty       (empty),
        .out_full        (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pv;
        logic [DW-1:0] pt;
        logic [CW-1:0] cnt;
        logic          emp;
        logic          ful;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    int            m_tos, m_count, m_ck_tos, m_ck_count;
    logic          m_pv;
    logic [DW-1:0] m_pt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tos = 0; m_count = 0; m_ck_tos = 0; m_ck_count = 0;
        m_pv = 1'b0; m_pt = '0;
    endtask

    task automatic model_push(input logic [DW-1:0] p);
        m_tos = (m_tos + 1) % DEPTH;
        m_mem[m_tos] = p + 64'd4;
        if (m_count < DEPTH) m_count++;
    endtask

    task automatic model(input logic v, input logic [6:0] opc, input logic [4:0] d,
                         input logic [4:0] s, input logic [DW-1:0] p, input logic ck,
                         input logic rec);
        bit dl, sl;
        int op, pre_tos, pre_cnt;
        dl = (d == 5'd1) || (d == 5'd5);
        sl = (s == 5'd1) || (s == 5'd5);
        op = 0;
        pre_tos = m_tos;
        pre_cnt = m_count;
        if (v && !rec) begin
            if (opc == JAL && dl) op = 1;
            else if (opc == JALR) begin
                if (dl && !sl)      op = 1;
                else if (!dl && sl) op = 2;
                else if (dl && sl)  op = (d != s) ? 3 : 1;
            end
        end
        m_pv = 1'b0;
        if (rec) begin
            m_tos = m_ck_tos;
            m_count = m_ck_count;
        end else begin
            case (op)
                1: model_push(p);
                2: if (m_count > 0) begin
                       m_pv = 1'b1; m_pt = m_mem[m_tos];
                       m_tos = (m_tos + DEPTH - 1) % DEPTH; m_count--;
                   end
                3: if (m_count > 0) begin
                       m_pv = 1'b1; m_pt = m_mem[m_tos]; m_mem[m_tos] = p + 64'd4;
                   end else model_push(p);
                default: ;
            endcase
            if (ck) begin
                m_ck_tos = pre_tos;
                m_ck_count = pre_cnt;
            end
        end
    endtask

    task automatic step(input logic v, input logic [6:0] opc, input logic [4:0] d,
                        input logic [4:0] s, input logic [DW-1:0] p, input logic ck,
                        input logic rec);
        exp_t e;
        valid = v; opcode = opc; rd = d; rs1 = s; pc = p; checkpoint = ck; recover = rec;
        model(v, opc, d, s, p, ck, rec);
        sb.push_back('{m_pv, m_pt, CW'(m_count), m_count == 0, m_count == DEPTH});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pred_valid", DW'(pred_valid), DW'(e.pv));
        chk("pred_target", pred_target, e.pt);
        chk("count", DW'(count), DW'(e.cnt));
        chk("empty", DW'(empty), DW'(e.emp));
        chk("full", DW'(full), DW'(e.ful));
        $display("step v=%0b op=%0h rd=%0d rs1=%0d pc=%0h ck=%0b rec=%0b -> pv=%0b tgt=%0h cnt=%0d",
                 v, opc, d, s, p, ck, rec, pred_valid, pred_target, count);
    endtask

    task automatic push(input logic [DW-1:0] p);   step(1, JAL, 5'd1, 5'd0, p, 0, 0); endtask
    task automatic pop();                          step(1, JALR, 5'd0, 5'd1, '0, 0, 0); endtask
    task automatic idle();                         step(0, ALU, 5'd0, 5'd0, '0, 0, 0); endtask

    initial begin
        logic [4:0] regs [4];
        logic [6:0] opcs [3];
        regs = '{5'd0, 5'd1, 5'd5, 5'd2};
        opcs = '{JAL, JALR, ALU};
        rst_n = 1'b0; valid = 0; opcode = '0; rd = '0; rs1 = '0; pc = '0;
        checkpoint = 0; recover = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pv", DW'(pred_valid), '0);
        chk("rst_tgt", pred_target, '0);
        chk("rst_cnt", DW'(count), '0);
        chk("rst_empty", DW'(empty), 64'd1);
        chk("rst_full", DW'(full), '0);
        rst_n = 1'b1;

        // Three calls, three returns in LIFO order.
        push(64'h1000); push(64'h2000); push(64'h3000);
        pop(); chk("ret1", pred_target, 64'h3004);
        pop(); chk("ret2", pred_target, 64'h2004);
        pop(); chk("ret3", pred_target, 64'h1004);
        chk("ret_empty", DW'(empty), 64'd1);

        // Overflow wraps onto the oldest entry, then drain plus one underflow.
        for (int k = 1; k <= 9; k++) begin
            push(64'h100 * k);
            if (k >= 8) chk("ovf_full", DW'(full), 64'd1);
        end
        for (int k = 9; k >= 2; k--) begin
            pop();
            chk("ovf_pop", pred_target, 64'h100 * k + 64'd4);
        end
        pop(); chk("underflow_pv", DW'(pred_valid), '0);

        // Pop-then-push replaces the top in place.
        push(64'h1000);
        step(1, JALR, 5'd5, 5'd1, 64'h5000, 0, 0);
        chk("pp_tgt", pred_target, 64'h1004);
        chk("pp_cnt", DW'(count), 64'd1);
        pop(); chk("pp_next", pred_target, 64'h5004);

        // rd == rs1 == link is push-only; non-linking jumps and non-jumps do nothing.
        push(64'h2000); push(64'h3000);
        step(1, JALR, 5'd1, 5'd1, 64'h4000, 0, 0);
        chk("same_link_cnt", DW'(count), 64'd3);
        step(1, JALR, 5'd0, 5'd0, 64'h4100, 0, 0);
        step(1, ALU,  5'd1, 5'd0, 64'h4200, 0, 0);
        chk("nojump_cnt", DW'(count), 64'd3);
        pop(); pop(); pop();

        // Checkpoint and recovery.
        push(64'hA000);
        step(0, ALU, 5'd0, 5'd0, '0, 1, 0);
        push(64'hB000); push(64'hC000); pop();
        step(0, ALU, 5'd0, 5'd0, '0, 0, 1);
        chk("rec_cnt", DW'(count), 64'd1);
        chk("rec_pv", DW'(pred_valid), '0);
        pop(); chk("rec_pop", pred_target, 64'hA004);
        push(64'hD000);
        step(0, ALU, 5'd0, 5'd0, '0, 1, 0);
        push(64'hE000); push(64'hF000);
        step(0, ALU, 5'd0, 5'd0, '0, 1, 1);
        chk("ckrec_cnt", DW'(count), 64'd1);
        push(64'h7000);
        step(0, ALU, 5'd0, 5'd0, '0, 0, 1);
        chk("rec_keep_ck", DW'(count), 64'd1);
        step(1, JAL, 5'd1, 5'd0, 64'h8000, 0, 1);
        chk("rec_drop_push", DW'(count), 64'd1);
        pop(); chk("rec_pop2", pred_target, 64'hD004);

        // Mixed random traffic.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 7) != 0), opcs[$urandom_range(0, 2)],
                 regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)],
                 {32'h0, $urandom} & ~64'h3,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
        end

        // Asynchronous reset with a live prediction on the outputs.
        step(0, ALU, 5'd0, 5'd0, '0, 0, 1);
        while (m_count < 5) push(64'h9000 + 64'h10 * m_count);
        while (m_count > 5) pop();
        pop();
        chk("pre_rst_pv", DW'(pred_valid), 64'd1);
        chk("pre_rst_cnt", DW'(count), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_pv", DW'(pred_valid), '0);
        chk("arst_tgt", pred_target, '0);
        chk("arst_cnt", DW'(count), '0);
        chk("arst_empty", DW'(empty), 64'd1);
        chk("arst_full", DW'(full), '0);
        @(negedge clk);
        rst_n = 1'b1;
        pop(); chk("post_rst_underflow", DW'(pred_valid), '0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
